// File: rtl/vga_timing_gen.sv
// VGA raster timing generator driven by a one-cycle pixel strobe in the system clock domain.
// Produces registered sync, active-video, coordinate and line/frame start outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_h_wrap;
  logic       w_v_wrap;

  always_comb begin
    w_h_wrap = (r_h == H_LAST);
    w_v_wrap = (r_v == V_LAST);
    w_h_nxt  = w_h_wrap ? 10'd0 : r_h + 10'd1;
    w_v_nxt  = r_v;
    if (w_h_wrap) begin
      w_v_nxt = w_v_wrap ? 10'd0 : r_v + 10'd1;
    end
  end

  // Counters park at the last position so the first strobe after reset lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h         <= H_LAST;
      r_v         <= V_LAST;
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        r_h         <= w_h_nxt;
        r_v         <= w_v_nxt;
        h_cnt       <= w_h_nxt;
        v_cnt       <= w_v_nxt;
        hsync       <= ((w_h_nxt >= HS_BEG) && (w_h_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync       <= ((w_v_nxt >= VS_BEG) && (w_v_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        video_on    <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
        line_start  <= w_h_wrap;
        frame_start <= w_h_wrap && w_v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: one default-timing instance for line-level checks, two reduced-timing
// instances (both sync polarities) for frame-level, sparse-strobe and async-reset checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic       d0_hs, d0_vs, d0_vo, d0_ls, d0_fs;
  logic [9:0] d0_h, d0_v;
  logic       d1_hs, d1_vs, d1_vo, d1_ls, d1_fs;
  logic [9:0] d1_h, d1_v;
  logic       d2_hs, d2_vs, d2_vo, d2_ls, d2_fs;
  logic [9:0] d2_h, d2_v;

  logic [24:0] d0_vec, d1_vec, d2_vec;
  assign d0_vec = {d0_hs, d0_vs, d0_vo, d0_h, d0_v, d0_ls, d0_fs};
  assign d1_vec = {d1_hs, d1_vs, d1_vo, d1_h, d1_v, d1_ls, d1_fs};
  assign d2_vec = {d2_hs, d2_vs, d2_vo, d2_h, d2_v, d2_ls, d2_fs};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pos   = -1;
  bit fresh = 1'b0;
  int last_ls = -1;

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(d0_hs), .vsync(d0_vs), .video_on(d0_vo),
    .h_cnt(d0_h), .v_cnt(d0_v), .line_start(d0_ls), .frame_start(d0_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(d1_hs), .vsync(d1_vs), .video_on(d1_vo),
    .h_cnt(d1_h), .v_cnt(d1_v), .line_start(d1_ls), .frame_start(d1_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(d2_hs), .vsync(d2_vs), .video_on(d2_vo),
    .h_cnt(d2_h), .v_cnt(d2_v), .line_start(d2_ls), .frame_start(d2_fs)
  );

  // Expected outputs from the strobe index since reset release (pos<0: reset state).
  function automatic logic [24:0] exp_vec(int p, bit fr, int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb, bit pol);
    int ht, vt, h, v;
    logic hsy, vsy, vo, ls, fs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (p < 0) return {~pol, ~pol, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
    h   = p % ht;
    v   = (p / ht) % vt;
    hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
    vsy = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
    vo  = (h < ha) && (v < va);
    ls  = fr && (h == 0);
    fs  = fr && (h == 0) && (v == 0);
    return {hsy, vsy, vo, 10'(h), 10'(v), ls, fs};
  endfunction

  function automatic logic [24:0] exp_big(int p, bit fr);
    return exp_vec(p, fr, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic logic [24:0] exp_small(int p, bit fr, bit pol);
    return exp_vec(p, fr, 10, 2, 3, 2, 6, 1, 2, 1, pol);
  endfunction

  task automatic tick(input bit en);
    pix_en = en;
    @(posedge clk);
    #1;
    cyc++;
    if (en) pos++;
    fresh = en;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    pix_en = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    pos = -1;
    fresh = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (d0_vec !== {2'b11, 23'd0}) begin
      bad++; $display("FAIL reset_d0 got=%h exp=%h", d0_vec, {2'b11, 23'd0});
    end
    total++;
    if (d2_vec !== 25'd0) begin
      bad++; $display("FAIL reset_d2_pol got=%h exp=%h", d2_vec, 25'd0);
    end
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (d1_vec !== {2'b11, 23'd0}) begin
      bad++; $display("FAIL reset_ignores_strobe got=%h exp=%h", d1_vec, {2'b11, 23'd0});
    end
    rst = 1'b0;
    pos = -1;
    tick(1'b1);
    last_ls = cyc;
    total++;
    if (d0_vec !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL first_strobe got=%h exp=%h", d0_vec, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1});
    end
    tick(1'b1);
    total++;
    if (d0_vec !== {1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL pulse_one_clk got=%h exp=%h", d0_vec, {1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_line;
    int hs_low = 0;
    while (pos < 801) begin
      tick(1'b1);
      total++;
      if (d0_vec !== exp_big(pos, fresh)) begin
        bad++; $display("FAIL line pos=%0d got=%h exp=%h", pos, d0_vec, exp_big(pos, fresh));
      end
      if (d0_v == 10'd0 && d0_hs == 1'b0) hs_low++;
      if (d0_ls) begin
        total++;
        if (cyc - last_ls !== 800) begin
          bad++; $display("FAIL line_period got=%0d exp=800", cyc - last_ls);
        end
        last_ls = cyc;
      end
    end
    total++;
    if (hs_low !== 96) begin
      bad++; $display("FAIL hsync_width got=%0d exp=96", hs_low);
    end
  endtask

  task automatic test_frame;
    int vs_low = 0;
    int last_fs = -1;
    do_reset();
    while (pos < 345) begin
      tick(1'b1);
      total++;
      if (d1_vec !== exp_small(pos, fresh, 1'b0)) begin
        bad++; $display("FAIL frame pos=%0d got=%h exp=%h", pos, d1_vec, exp_small(pos, fresh, 1'b0));
      end
      if (pos < 170 && d1_vs == 1'b0) vs_low++;
      if (d1_fs) begin
        if (last_fs >= 0) begin
          total++;
          if (cyc - last_fs !== 170) begin
            bad++; $display("FAIL frame_period got=%0d exp=170", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
    end
    total++;
    if (vs_low !== 34) begin
      bad++; $display("FAIL vsync_width got=%0d exp=34", vs_low);
    end
  endtask

  task automatic test_sparse;
    int fs_cyc[3];
    int nfs = 0;
    do_reset();
    for (int i = 0; i < 706; i++) begin
      tick((i % 2 == 0) && !(i >= 400 && i < 420));
      total++;
      if (d1_vec !== exp_small(pos, fresh, 1'b0)) begin
        bad++; $display("FAIL sparse i=%0d got=%h exp=%h", i, d1_vec, exp_small(pos, fresh, 1'b0));
      end
      if (d1_fs && nfs < 3) begin
        fs_cyc[nfs] = cyc;
        nfs++;
      end
    end
    total++;
    if (nfs !== 3) begin
      bad++; $display("FAIL sparse_fs_count got=%0d exp=3", nfs);
    end else begin
      total++;
      if (fs_cyc[1] - fs_cyc[0] !== 340) begin
        bad++; $display("FAIL sparse_period got=%0d exp=340", fs_cyc[1] - fs_cyc[0]);
      end
      total++;
      if (fs_cyc[2] - fs_cyc[1] !== 360) begin
        bad++; $display("FAIL gap_period got=%0d exp=360", fs_cyc[2] - fs_cyc[1]);
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    while (pos < 3 * 17 + 5) tick(1'b1);
    total++;
    if (d1_vec !== exp_small(pos, fresh, 1'b0)) begin
      bad++; $display("FAIL pre_async got=%h exp=%h", d1_vec, exp_small(pos, fresh, 1'b0));
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (d1_vec !== {2'b11, 23'd0}) begin
      bad++; $display("FAIL async_d1 got=%h exp=%h", d1_vec, {2'b11, 23'd0});
    end
    total++;
    if (d2_vec !== 25'd0) begin
      bad++; $display("FAIL async_d2 got=%h exp=%h", d2_vec, 25'd0);
    end
    total++;
    if (d0_vec !== {2'b11, 23'd0}) begin
      bad++; $display("FAIL async_d0 got=%h exp=%h", d0_vec, {2'b11, 23'd0});
    end
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    pos = -1;
    tick(1'b1);
    total++;
    if (d1_vec !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL after_async got=%h exp=%h", d1_vec, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_sync_pol;
    int hs_hi = 0;
    do_reset();
    total++;
    if (d2_vec !== exp_small(-1, 1'b0, 1'b1)) begin
      bad++; $display("FAIL pol_reset got=%h exp=%h", d2_vec, exp_small(-1, 1'b0, 1'b1));
    end
    while (pos < 171) begin
      tick(1'b1);
      total++;
      if (d2_vec !== exp_small(pos, fresh, 1'b1)) begin
        bad++; $display("FAIL pol pos=%0d got=%h exp=%h", pos, d2_vec, exp_small(pos, fresh, 1'b1));
      end
      if (pos < 170 && d2_hs == 1'b1) hs_hi++;
    end
    total++;
    if (hs_hi !== 30) begin
      bad++; $display("FAIL pol_hsync_count got=%0d exp=30", hs_hi);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_sparse();
    test_async_reset();
    test_sync_pol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
